axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 slave SRAM model that serves the instruction-fetch master's AR/R requests and the load/store master's AW/W/B requests.
- Sits directly upstream of the fetch stage: every fetch (reset PC 0x2000_0000, arlen=0) is answered here.
- Supports single-beat and INCR/FIXED bursts with configurable response latency, so stall paths in fetch/decode handshakes get exercised.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words; power of two.
- READ_LATENCY, 1, cycles from AR handshake to first rvalid; legal range 1..15.
- WRITE_LATENCY, 1, cycles from last W handshake to bvalid; legal range 1..15.
- INIT_FILE, "", hex image loaded with $readmemh when non-empty.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- arvalid in 1, arready out 1, araddr in 32, arid in 4, arlen in 8, arsize in 3, arburst in 2: read address channel.
- rvalid out 1, rready in 1, rdata out 32, rresp out 2, rlast out 1, rid out 4: read data channel.
- awvalid in 1, awready out 1, awaddr in 32, awid in 4, awlen in 8, awsize in 3, awburst in 2: write address channel.
- wvalid in 1, wready out 1, wdata in 32, wstrb in 4, wlast in 1: write data channel.
- bvalid out 1, bready in 1, bresp out 2, bid out 4: write response channel.

Behaviour:
- Reset values:
  - arready=1, awready=1 (both are combinational idle decodes).
  - rvalid=0, rlast=0, rresp=0, rdata=0, rid=0.
  - wready=0, bvalid=0, bresp=0, bid=0.
  - Memory contents are not reset.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On arvalid&&arready, latch addr/id/len/burst, load delay counter with READ_LATENCY-1, go to R_WAIT.
  - R_WAIT: counter decrements each cycle. At 0, register rdata/rresp/rlast, assert rvalid, go to R_DATA.
  - R_DATA: rvalid and all R outputs stay stable until rready.
    - On handshake with a beat remaining: address +4 (INCR) or held (FIXED); next beat is valid on the following cycle (1-cycle gap, rvalid=0).
    - On handshake of the last beat (rlast=1): rvalid=0, return to R_IDLE. A new AR is accepted the cycle after.
- Bursts:
  - Beat count is arlen+1, up to 256.
  - arsize is ignored; every access is a 32-bit word.
  - WRAP (2'b10) is treated as INCR.
- Address decode:
  - Index = (addr-BASE_ADDR)>>2. Low two address bits are ignored.
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH): rresp=2'b11 (DECERR), rdata=0, burst continues beat by beat.
  - An INCR burst crossing the top of the range returns DECERR for the out-of-range beats only.
- Write FSM states: W_IDLE, W_DATA, W_WAIT, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr/id/len/burst, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb (out-of-range writes are dropped and mark the error). Address advances per burst rules.
  - On the beat where the beat counter reaches len: go to W_WAIT. wlast mismatch with beat count sets bresp=2'b10 (SLVERR).
  - W_WAIT: count WRITE_LATENCY-1 cycles, then bvalid=1 in W_RESP.
  - W_RESP: hold until bready, then W_IDLE.
  - bresp priority: DECERR > SLVERR > OKAY.
- Read and write FSMs are independent.
  - Same-cycle write and read of the same word: read data is sampled in the cycle rvalid rises. A write committed in an earlier cycle is visible; a write in the same cycle is not (read-before-write).
- Reset mid-transaction aborts both FSMs immediately to idle; outstanding beats are dropped.

Optional Feature:
- Macro: AXI_SRAM_RAND_DELAY_EN.
- When defined: a 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11, advanced every cycle) sets per-transaction latency to 1+lfsr[3:0]. This applies to the first read beat and to the B response. It also randomly holds awready/arready low for one cycle when lfsr[4]=1.
- When not defined: fixed READ_LATENCY/WRITE_LATENCY, and ready signals exactly as specified above.

Decomposition:
- Shared package holds:
  - AXI response codes: OKAY=0, SLVERR=2, DECERR=3.
  - Burst encodings: FIXED=0, INCR=1, WRAP=2.
  - Default ID/LEN/SIZE/BURST constants, shared with the existing master defaults header.
  - Read and write FSM state enums.
- One natural sub-module, axi_sram_lfsr: the LFSR delay generator, instantiated only under the macro.

Test Plan:
- Reset, then AR addr=0x2000_0000, arlen=0, with INIT_FILE word0=0x00000413 and READ_LATENCY=3: rvalid exactly 3 cycles after the handshake, rdata=0x00000413, rlast=1, rresp=0.
- rready held low for 5 cycles during R_DATA: rvalid, rdata and rid stay stable each cycle; arready=0 until one cycle after the handshake.
- INCR read arlen=3 from 0x2000_0008: four beats returning words 2..5, rlast only on beat 4, rid echoes arid=4'h5.
- AW 0x2000_0010, W 0xDEADBEEF with wstrb=4'b0101, then read back: rdata=0x00AD00EF over prior zero contents; bresp=0, bid matches awid.
- AR to 0x1000_0000: rresp=2'b11, rdata=0. AW to the same address: bresp=2'b11, memory unchanged.
- Assert rst during R_WAIT of a burst: rvalid=0 and arready=1 the same cycle; a fresh AR after reset is served correctly.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared AXI codes, master defaults, FSM states and burst address helper for the SRAM slave.
package axi_sram_pkg;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] BURST_WRAP = 2'd2;
  localparam logic [3:0] AXI_DEF_ID = 4'h0;
  localparam logic [7:0] AXI_DEF_LEN = 8'h00;
  localparam logic [2:0] AXI_DEF_SIZE = 3'd2;
  localparam logic [1:0] AXI_DEF_BURST = BURST_INCR;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
  // WRAP deliberately advances like INCR; only FIXED holds the address
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return burst == BURST_FIXED ? addr : addr + 32'd4;
  endfunction
endpackage

// File: rtl/axi_sram_lfsr.sv
// axi_sram_lfsr: free-running 16-bit Galois LFSR (taps 16,14,13,11) for randomized response delays.
// Ports: clk, rst (async, active-high), lfsr (current state).
module axi_sram_lfsr
  import axi_sram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 SRAM slave with independent read (AR/R) and write (AW/W/B) FSMs and fixed latencies.
// Ports: clk, rst (async, active-high), AR/R read channels, AW/W/B write channels, 32-bit data, 4-bit ids.
// Define AXI_SRAM_RAND_DELAY_EN for LFSR-driven per-transaction latency and random ready holds.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int DEPTH = 4096,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_LATENCY = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  logic [31:0] mem [DEPTH];
  r_state_t r_state, r_state_n;
  logic [31:0] r_addr, r_addr_n, rdata_n;
  logic [3:0] r_id, r_id_n, r_cnt, r_cnt_n, rid_n;
  logic [7:0] r_left, r_left_n;
  logic [1:0] r_burst, r_burst_n, rresp_n;
  logic rvalid_n, rlast_n;
  w_state_t w_state, w_state_n;
  logic [31:0] w_addr, w_addr_n;
  logic [3:0] w_id, w_id_n, w_cnt, w_cnt_n, bid_n;
  logic [7:0] w_len, w_len_n, w_beat, w_beat_n;
  logic [1:0] w_burst, w_burst_n, bresp_n;
  logic w_dec, w_dec_n, w_slv, w_slv_n, bvalid_n;
  logic [3:0] r_lat, w_lat;
  logic hold;
  logic [31:0] r_off, w_off;
  logic r_in, w_in;
  logic [AW-1:0] r_idx, w_idx;
  logic unused;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;
  axi_sram_lfsr u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));
  assign r_lat = lfsr[3:0];
  assign w_lat = lfsr[3:0];
  assign hold = lfsr[4];
  assign unused = ^{arsize, awsize, lfsr[15:5]};
`else
  assign r_lat = 4'(READ_LATENCY - 1);
  assign w_lat = 4'(WRITE_LATENCY - 1);
  assign hold = 1'b0;
  assign unused = ^{arsize, awsize};
`endif
  // offset arithmetic wraps below BASE_ADDR, so one unsigned compare covers both range ends
  assign r_off = r_addr - BASE_ADDR;
  assign w_off = w_addr - BASE_ADDR;
  assign r_in = r_off < SPAN;
  assign w_in = w_off < SPAN;
  assign r_idx = r_off[AW+1:2];
  assign w_idx = w_off[AW+1:2];
  assign arready = r_state == R_IDLE && !hold;
  assign awready = w_state == W_IDLE && !hold;
  assign wready = w_state == W_DATA;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= R_IDLE;
      r_addr <= '0;
      r_id <= '0;
      r_left <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
      rid <= '0;
    end else begin
      r_state <= r_state_n;
      r_addr <= r_addr_n;
      r_id <= r_id_n;
      r_left <= r_left_n;
      r_burst <= r_burst_n;
      r_cnt <= r_cnt_n;
      rvalid <= rvalid_n;
      rdata <= rdata_n;
      rresp <= rresp_n;
      rlast <= rlast_n;
      rid <= rid_n;
    end
  // rdata is captured from the array at the edge where rvalid rises, so a same-edge write is not seen
  always_comb begin
    r_state_n = r_state;
    r_addr_n = r_addr;
    r_id_n = r_id;
    r_left_n = r_left;
    r_burst_n = r_burst;
    r_cnt_n = r_cnt;
    rvalid_n = rvalid;
    rdata_n = rdata;
    rresp_n = rresp;
    rlast_n = rlast;
    rid_n = rid;
    unique case (r_state)
      R_IDLE: if (arvalid && arready) begin
        r_addr_n = araddr;
        r_id_n = arid;
        r_left_n = arlen;
        r_burst_n = arburst;
        r_cnt_n = r_lat;
        r_state_n = R_WAIT;
      end
      R_WAIT: if (r_cnt == 4'd0) begin
        rvalid_n = 1'b1;
        rdata_n = r_in ? mem[r_idx] : '0;
        rresp_n = r_in ? RESP_OKAY : RESP_DECERR;
        rlast_n = r_left == 8'd0;
        rid_n = r_id;
        r_state_n = R_DATA;
      end else r_cnt_n = r_cnt - 4'd1;
      R_DATA: if (rready) begin
        rvalid_n = 1'b0;
        if (rlast) begin
          rlast_n = 1'b0;
          r_state_n = R_IDLE;
        end else begin
          r_addr_n = next_addr(r_addr, r_burst);
          r_left_n = r_left - 8'd1;
          r_state_n = R_WAIT;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      w_addr <= '0;
      w_id <= '0;
      w_len <= '0;
      w_beat <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_dec <= 1'b0;
      w_slv <= 1'b0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
      bid <= '0;
    end else begin
      w_state <= w_state_n;
      w_addr <= w_addr_n;
      w_id <= w_id_n;
      w_len <= w_len_n;
      w_beat <= w_beat_n;
      w_burst <= w_burst_n;
      w_cnt <= w_cnt_n;
      w_dec <= w_dec_n;
      w_slv <= w_slv_n;
      bvalid <= bvalid_n;
      bresp <= bresp_n;
      bid <= bid_n;
    end
  always_comb begin
    w_state_n = w_state;
    w_addr_n = w_addr;
    w_id_n = w_id;
    w_len_n = w_len;
    w_beat_n = w_beat;
    w_burst_n = w_burst;
    w_cnt_n = w_cnt;
    w_dec_n = w_dec;
    w_slv_n = w_slv;
    bvalid_n = bvalid;
    bresp_n = bresp;
    bid_n = bid;
    unique case (w_state)
      W_IDLE: if (awvalid && awready) begin
        w_addr_n = awaddr;
        w_id_n = awid;
        w_len_n = awlen;
        w_beat_n = 8'd0;
        w_burst_n = awburst;
        w_dec_n = 1'b0;
        w_slv_n = 1'b0;
        w_state_n = W_DATA;
      end
      W_DATA: if (wvalid) begin
        w_dec_n = w_dec | !w_in;
        w_slv_n = w_slv | (wlast != (w_beat == w_len));
        if (w_beat == w_len) begin
          w_cnt_n = w_lat;
          w_state_n = W_WAIT;
        end else begin
          w_beat_n = w_beat + 8'd1;
          w_addr_n = next_addr(w_addr, w_burst);
        end
      end
      W_WAIT: if (w_cnt == 4'd0) begin
        bvalid_n = 1'b1;
        bresp_n = w_dec ? RESP_DECERR : w_slv ? RESP_SLVERR : RESP_OKAY;
        bid_n = w_id;
        w_state_n = W_RESP;
      end else w_cnt_n = w_cnt - 4'd1;
      W_RESP: if (bready) begin
        bvalid_n = 1'b0;
        w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (w_state == W_DATA && wvalid && w_in)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI read/write traffic checked against a word-array reference model.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int DEPTH = 64;
  localparam int RL = 3;
  localparam int WL = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0] arid, rid, awid, wstrb, bid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, rresp, awburst, bresp;
  logic [31:0] model [DEPTH];
  int checks = 0, errors = 0;
  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(4 * DEPTH);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int stall, output logic [31:0] first);
    logic [31:0] a, ed;
    int n, ns;
    first = '0;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = 3'd2;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("ar_busy", 32'(arready), 0);
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!rvalid && n < 40) begin @(negedge clk); n++; end
      if (!rvalid) begin chk("r_timeout", 0, 1); return; end
      if (k == 0) chk("r_latency", 32'(n), RL); else chk("r_gap", 32'(n), 1);
      ed = in_rng(a) ? model[widx(a)] : 32'h0;
      if (k == 0) first = rdata;
      chk("rdata", rdata, ed);
      chk("rresp", 32'(rresp), in_rng(a) ? 0 : 3);
      chk("rlast", 32'(rlast), 32'(k == int'(len)));
      chk("rid", 32'(rid), 32'(id));
      ns = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      repeat (ns) begin
        @(negedge clk);
        chk("r_hold_valid", 32'(rvalid), 1);
        chk("r_hold_data", rdata, ed);
        chk("r_hold_id", 32'(rid), 32'(id));
        chk("ar_hold", 32'(arready), 0);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("r_drop", 32'(rvalid), 0);
      if (burst != 2'd0) a = a + 32'd4;
    end
    chk("ar_free", 32'(arready), 1);
  endtask
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [3:0] s0, input bit rnd, input bit bad, output logic [1:0] resp);
    logic [31:0] a, d;
    logic [3:0] s;
    bit dec;
    int n;
    dec = 1'b0;
    resp = 2'bxx;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = 3'd2;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin chk("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      d = rnd ? $urandom : d0;
      s = rnd ? 4'($urandom) : s0;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = (k == int'(len)) && !bad;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin chk("w_timeout", 0, 1); wvalid = 1'b0; return; end
      if (in_rng(a)) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end else dec = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      if (burst != 2'd0) a = a + 32'd4;
    end
    n = 0;
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    chk("b_latency", 32'(n), WL);
    if (!bvalid) return;
    resp = bresp;
    chk("bresp", 32'(bresp), dec ? 3 : bad ? 2 : 0);
    chk("bid", 32'(bid), 32'(id));
    repeat ($urandom_range(0, 2)) begin @(negedge clk); chk("b_hold", 32'(bvalid), 1); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", 32'(bvalid), 0);
    chk("aw_free", 32'(awready), 1);
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [31:0] d, a;
    logic [1:0] r;
    int n;
    {arvalid, rready, awvalid, wvalid, wlast, bready} = '0;
    {araddr, awaddr, wdata} = '0;
    {arid, awid, wstrb, arlen, awlen, arsize, awsize, arburst, awburst} = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_awready", 32'(awready), 1);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_bid", 32'(bid), 0);
    rst = 1'b0;
    @(negedge clk);
    do_write(BASE, 4'h1, 8'd63, 2'd1, 32'h0, 4'hf, 1'b0, 1'b0, r);
    do_write(BASE + 32'h10, 4'h9, 8'd0, 2'd1, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b0, r);
    chk("strb_bresp", 32'(r), 0);
    do_read(BASE + 32'h10, 4'h2, 8'd0, 2'd1, -1, d);
    chk("strb_merge", d, 32'h00AD00EF);
    do_write(BASE, 4'h3, 8'd0, 2'd1, 32'h00000413, 4'hf, 1'b0, 1'b0, r);
    do_read(BASE, 4'h0, 8'd0, 2'd1, 5, d);
    chk("fetch_word0", d, 32'h00000413);
    do_write(BASE + 32'h8, 4'h4, 8'd3, 2'd1, 32'h0, 4'h0, 1'b1, 1'b0, r);
    do_read(BASE + 32'h8, 4'h5, 8'd3, 2'd1, -1, d);
    do_read(32'h1000_0000, 4'h6, 8'd0, 2'd1, -1, d);
    chk("decerr_rdata", d, 0);
    do_write(32'h1000_0000, 4'h7, 8'd0, 2'd1, 32'hFFFFFFFF, 4'hf, 1'b0, 1'b0, r);
    chk("decerr_bresp", 32'(r), 3);
    do_read(BASE + 32'hF8, 4'h8, 8'd3, 2'd1, -1, d);
    do_write(BASE + 32'hF8, 4'h9, 8'd3, 2'd1, 32'h0, 4'h0, 1'b1, 1'b0, r);
    do_read(BASE + 32'hF0, 4'ha, 8'd3, 2'd2, -1, d);
    do_write(BASE + 32'h20, 4'hb, 8'd2, 2'd0, 32'h0, 4'h0, 1'b1, 1'b0, r);
    do_read(BASE + 32'h20, 4'hc, 8'd2, 2'd0, -1, d);
    do_write(BASE + 32'h30, 4'hd, 8'd1, 2'd1, 32'h0, 4'h0, 1'b1, 1'b1, r);
    chk("slverr_bresp", 32'(r), 2);
    for (int t = 0; t < 40; t++) begin
      a = BASE + 32'($urandom_range(0, 72)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 1) == 1)
        do_read(a, 4'($urandom), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), -1, d);
      else
        do_write(a, 4'($urandom), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 32'h0, 4'h0, 1'b1,
                 $urandom_range(0, 7) == 0, r);
    end
    arvalid = 1'b1; araddr = BASE + 32'h4; arid = 4'h3; arlen = 8'd7; arburst = 2'd1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rst_wait_busy", 32'(arready), 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_wait_rvalid", 32'(rvalid), 0);
    chk("rst_wait_arready", 32'(arready), 1);
    @(negedge clk);
    rst = 1'b0;
    arvalid = 1'b1; araddr = BASE; arid = 4'h1; arlen = 8'd3; arburst = 2'd1;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    chk("rst_data_pre", 32'(rvalid), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_data_rvalid", 32'(rvalid), 0);
    chk("rst_data_arready", 32'(arready), 1);
    chk("rst_data_rlast", 32'(rlast), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(BASE + 32'h4, 4'he, 8'd2, 2'd1, -1, d);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
